// File: rtl/lane_judge_scorer_if.sv
// Bundle between the note/key producers and the lane judge: game time, note loads,
// key levels in; judgement pulses and score/combo counters out.
interface lane_judge_scorer_if #(
  parameter int LANES   = 8,
  parameter int TICK_W  = 10,
  parameter int SCORE_W = 11,
  parameter int COMBO_W = 8
);
  logic [TICK_W-1:0]  tick;
  logic               note_valid;
  logic [TICK_W-1:0]  note_time;
  logic [LANES-1:0]   note_mask;
  logic [LANES-1:0]   user_key;
  logic [LANES-1:0]   perfect_mask;
  logic [LANES-1:0]   good_mask;
  logic [LANES-1:0]   miss_mask;
  logic [SCORE_W-1:0] score;
  logic [COMBO_W-1:0] combo;
  logic [COMBO_W-1:0] max_combo;

  modport master (
    output tick, note_valid, note_time, note_mask, user_key,
    input  perfect_mask, good_mask, miss_mask, score, combo, max_combo
  );

  modport slave (
    input  tick, note_valid, note_time, note_mask, user_key,
    output perfect_mask, good_mask, miss_mask, score, combo, max_combo
  );
endinterface

// File: rtl/lane_judge_scorer.sv
// Multi-lane rhythm judge: one pending note per lane, PERFECT/GOOD/MISS classification
// on key rising edges or timeout, saturating score and combo tracking.
module lane_judge_scorer #(
  parameter int LANES       = 8,
  parameter int TICK_W      = 10,
  parameter int WIN_PERFECT = 1,
  parameter int WIN_GOOD    = 3,
  parameter int PTS_PERFECT = 3,
  parameter int PTS_GOOD    = 1,
  parameter int SCORE_W     = 11,
  parameter int COMBO_W     = 8
) (
  input logic                clock_i,
  input logic                reset_i,
  lane_judge_scorer_if.slave bus_if
);

  localparam int SUM_W  = SCORE_W + $clog2(LANES) + 2;
  localparam int CNT_W  = $clog2(LANES + 1);
  localparam int CSUM_W = COMBO_W + CNT_W;

  localparam logic signed [TICK_W-1:0] WP = TICK_W'(WIN_PERFECT);
  localparam logic signed [TICK_W-1:0] WG = TICK_W'(WIN_GOOD);
  localparam logic [SCORE_W-1:0]       SCORE_MAX = '1;
  localparam logic [COMBO_W-1:0]       COMBO_MAX = '1;

  logic [LANES-1:0]   key_prev_q, key_prev_d;
  logic [LANES-1:0]   pend_q, pend_d;
  logic [TICK_W-1:0]  pt_q [LANES];
  logic [TICK_W-1:0]  pt_d [LANES];
  logic [LANES-1:0]   perfect_q, perfect_d;
  logic [LANES-1:0]   good_q, good_d;
  logic [LANES-1:0]   miss_q, miss_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [COMBO_W-1:0] combo_q, combo_d;
  logic [COMBO_W-1:0] max_combo_q, max_combo_d;

  logic [LANES-1:0]          key_edge;
  logic signed [TICK_W-1:0]  delta [LANES];
  logic [LANES-1:0]          in_perf, in_good, timeout, load, still_pend;
  logic [CNT_W-1:0]          n_perf, n_good;
  logic [SUM_W-1:0]          score_sum;
  logic [CSUM_W-1:0]         combo_sum;

  // Per-lane judgement; evaluation always sees the pending state from before any load.
  always_comb begin
    key_edge   = bus_if.user_key & ~key_prev_q;
    key_prev_d = bus_if.user_key;
    in_perf    = '0;
    in_good    = '0;
    timeout    = '0;
    load       = '0;
    still_pend = '0;
    perfect_d  = '0;
    good_d     = '0;
    miss_d     = '0;
    pend_d     = '0;
    n_perf     = '0;
    n_good     = '0;
    for (int i = 0; i < LANES; i++) begin
      delta[i] = $signed(bus_if.tick - pt_q[i]);
      pt_d[i]  = pt_q[i];
    end
    for (int i = 0; i < LANES; i++) begin
      in_perf[i]    = (delta[i] >= -WP) && (delta[i] <= WP);
      in_good[i]    = (delta[i] >= -WG) && (delta[i] <= WG);
      timeout[i]    = pend_q[i] && (delta[i] > WG);
      load[i]       = bus_if.note_valid & bus_if.note_mask[i];
      perfect_d[i]  = pend_q[i] & key_edge[i] & in_perf[i];
      good_d[i]     = pend_q[i] & key_edge[i] & ~in_perf[i] & in_good[i];
      still_pend[i] = pend_q[i] & ~perfect_d[i] & ~good_d[i] & ~timeout[i];
      // A note displaced by a reload counts as missed in the same cycle.
      miss_d[i]     = timeout[i] | (load[i] & still_pend[i]);
      pend_d[i]     = load[i] | still_pend[i];
      if (load[i]) pt_d[i] = bus_if.note_time;
      n_perf = n_perf + CNT_W'(perfect_d[i]);
      n_good = n_good + CNT_W'(good_d[i]);
    end

    score_sum = SUM_W'(score_q)
              + SUM_W'(PTS_PERFECT) * SUM_W'(n_perf)
              + SUM_W'(PTS_GOOD) * SUM_W'(n_good);
    if (score_sum > SUM_W'(SCORE_MAX)) score_d = SCORE_MAX;
    else                               score_d = score_sum[SCORE_W-1:0];

    combo_sum = CSUM_W'(combo_q) + CSUM_W'(n_perf) + CSUM_W'(n_good);
    if (|miss_d)                           combo_d = '0;
    else if (combo_sum > CSUM_W'(COMBO_MAX)) combo_d = COMBO_MAX;
    else                                   combo_d = combo_sum[COMBO_W-1:0];

    max_combo_d = (combo_d > max_combo_q) ? combo_d : max_combo_q;
  end

  // Reset captures the live key level so a key held through reset yields no edge.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      key_prev_q  <= bus_if.user_key;
      pend_q      <= '0;
      perfect_q   <= '0;
      good_q      <= '0;
      miss_q      <= '0;
      score_q     <= '0;
      combo_q     <= '0;
      max_combo_q <= '0;
      for (int i = 0; i < LANES; i++) pt_q[i] <= '0;
    end else begin
      key_prev_q  <= key_prev_d;
      pend_q      <= pend_d;
      perfect_q   <= perfect_d;
      good_q      <= good_d;
      miss_q      <= miss_d;
      score_q     <= score_d;
      combo_q     <= combo_d;
      max_combo_q <= max_combo_d;
      for (int i = 0; i < LANES; i++) pt_q[i] <= pt_d[i];
    end
  end

  assign bus_if.perfect_mask = perfect_q;
  assign bus_if.good_mask    = good_q;
  assign bus_if.miss_mask    = miss_q;
  assign bus_if.score        = score_q;
  assign bus_if.combo        = combo_q;
  assign bus_if.max_combo    = max_combo_q;

endmodule

// File: tb/tb_lane_judge_scorer.sv
// Directed bench for lane_judge_scorer: per-cycle vector table plus reset and
// score-saturation sequences on a narrow-score instance.
module tb_lane_judge_scorer;

  typedef struct {
    logic        nv;
    logic [9:0]  nt;
    logic [7:0]  nm;
    logic [7:0]  key;
    logic [9:0]  tk;
    logic [7:0]  ep;
    logic [7:0]  eg;
    logic [7:0]  em;
    logic [10:0] esc;
    logic [7:0]  eco;
    logic [7:0]  emx;
  } vec_t;

  logic clk;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t vecs[$];

  lane_judge_scorer_if                  bus_a ();
  lane_judge_scorer_if #(.SCORE_W(4))   bus_b ();

  lane_judge_scorer dut_a (.clock_i(clk), .reset_i(rst), .bus_if(bus_a));
  lane_judge_scorer #(.SCORE_W(4)) dut_b (.clock_i(clk), .reset_i(rst), .bus_if(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic nv, input logic [9:0] nt, input logic [7:0] nm,
                     input logic [7:0] key, input logic [9:0] tk,
                     input logic [7:0] ep, input logic [7:0] eg, input logic [7:0] em,
                     input logic [10:0] esc, input logic [7:0] eco, input logic [7:0] emx);
    vec_t v;
    v.nv = nv; v.nt = nt; v.nm = nm; v.key = key; v.tk = tk;
    v.ep = ep; v.eg = eg; v.em = em; v.esc = esc; v.eco = eco; v.emx = emx;
    vecs.push_back(v);
  endtask

  task automatic drive_a(input logic nv, input logic [9:0] nt, input logic [7:0] nm,
                         input logic [7:0] key, input logic [9:0] tk);
    bus_a.note_valid = nv; bus_a.note_time = nt; bus_a.note_mask = nm;
    bus_a.user_key = key;  bus_a.tick = tk;
  endtask

  task automatic drive_b(input logic nv, input logic [9:0] nt, input logic [7:0] nm,
                         input logic [7:0] key, input logic [9:0] tk);
    bus_b.note_valid = nv; bus_b.note_time = nt; bus_b.note_mask = nm;
    bus_b.user_key = key;  bus_b.tick = tk;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_a(input string tag, input logic [7:0] ep, input logic [7:0] eg,
                       input logic [7:0] em, input logic [10:0] esc,
                       input logic [7:0] eco, input logic [7:0] emx);
    chk({tag, ".perfect"},   32'(bus_a.perfect_mask), 32'(ep));
    chk({tag, ".good"},      32'(bus_a.good_mask),    32'(eg));
    chk({tag, ".miss"},      32'(bus_a.miss_mask),    32'(em));
    chk({tag, ".score"},     32'(bus_a.score),        32'(esc));
    chk({tag, ".combo"},     32'(bus_a.combo),        32'(eco));
    chk({tag, ".max_combo"}, 32'(bus_a.max_combo),    32'(emx));
  endtask

  initial begin
    rst = 1'b1;
    drive_a(1'b0, 10'd0, 8'h00, 8'h00, 10'd0);
    drive_b(1'b0, 10'd0, 8'h00, 8'h00, 10'd0);

    //   nv  nt     nm     key    tick    perf   good   miss   score  combo max
    add(1, 10'd100, 8'h01, 8'h00, 10'd98,  8'h00, 8'h00, 8'h00, 11'd0,  8'd0, 8'd0);
    add(0, 10'd0,   8'h00, 8'h00, 10'd99,  8'h00, 8'h00, 8'h00, 11'd0,  8'd0, 8'd0);
    add(0, 10'd0,   8'h00, 8'h01, 10'd100, 8'h01, 8'h00, 8'h00, 11'd3,  8'd1, 8'd1);
    add(0, 10'd0,   8'h00, 8'h00, 10'd101, 8'h00, 8'h00, 8'h00, 11'd3,  8'd1, 8'd1);
    add(1, 10'd200, 8'h04, 8'h00, 10'd199, 8'h00, 8'h00, 8'h00, 11'd3,  8'd1, 8'd1);
    add(0, 10'd0,   8'h00, 8'h04, 10'd203, 8'h00, 8'h04, 8'h00, 11'd4,  8'd2, 8'd2);
    add(0, 10'd0,   8'h00, 8'h00, 10'd204, 8'h00, 8'h00, 8'h00, 11'd4,  8'd2, 8'd2);
    add(1, 10'd210, 8'h04, 8'h00, 10'd205, 8'h00, 8'h00, 8'h00, 11'd4,  8'd2, 8'd2);
    add(0, 10'd0,   8'h00, 8'h04, 10'd207, 8'h00, 8'h04, 8'h00, 11'd5,  8'd3, 8'd3);
    add(0, 10'd0,   8'h00, 8'h00, 10'd208, 8'h00, 8'h00, 8'h00, 11'd5,  8'd3, 8'd3);
    add(1, 10'd240, 8'h09, 8'h00, 10'd239, 8'h00, 8'h00, 8'h00, 11'd5,  8'd3, 8'd3);
    add(0, 10'd0,   8'h00, 8'h09, 10'd241, 8'h09, 8'h00, 8'h00, 11'd11, 8'd5, 8'd5);
    add(0, 10'd0,   8'h00, 8'h00, 10'd242, 8'h00, 8'h00, 8'h00, 11'd11, 8'd5, 8'd5);
    add(1, 10'd300, 8'h02, 8'h00, 10'd299, 8'h00, 8'h00, 8'h00, 11'd11, 8'd5, 8'd5);
    add(0, 10'd0,   8'h00, 8'h00, 10'd303, 8'h00, 8'h00, 8'h00, 11'd11, 8'd5, 8'd5);
    add(0, 10'd0,   8'h00, 8'h00, 10'd304, 8'h00, 8'h00, 8'h02, 11'd11, 8'd0, 8'd5);
    add(0, 10'd0,   8'h00, 8'h00, 10'd305, 8'h00, 8'h00, 8'h00, 11'd11, 8'd0, 8'd5);
    // early press four ticks ahead is ignored; the note then times out
    add(1, 10'd320, 8'h04, 8'h00, 10'd315, 8'h00, 8'h00, 8'h00, 11'd11, 8'd0, 8'd5);
    add(0, 10'd0,   8'h00, 8'h04, 10'd316, 8'h00, 8'h00, 8'h00, 11'd11, 8'd0, 8'd5);
    add(0, 10'd0,   8'h00, 8'h04, 10'd317, 8'h00, 8'h00, 8'h00, 11'd11, 8'd0, 8'd5);
    add(0, 10'd0,   8'h00, 8'h00, 10'd323, 8'h00, 8'h00, 8'h00, 11'd11, 8'd0, 8'd5);
    add(0, 10'd0,   8'h00, 8'h00, 10'd324, 8'h00, 8'h00, 8'h04, 11'd11, 8'd0, 8'd5);
    add(0, 10'd0,   8'h00, 8'h00, 10'd325, 8'h00, 8'h00, 8'h00, 11'd11, 8'd0, 8'd5);
    add(1, 10'd400, 8'h09, 8'h00, 10'd399, 8'h00, 8'h00, 8'h00, 11'd11, 8'd0, 8'd5);
    add(0, 10'd0,   8'h00, 8'h01, 10'd401, 8'h01, 8'h00, 8'h00, 11'd14, 8'd1, 8'd5);
    add(0, 10'd0,   8'h00, 8'h00, 10'd403, 8'h00, 8'h00, 8'h00, 11'd14, 8'd1, 8'd5);
    add(0, 10'd0,   8'h00, 8'h00, 10'd404, 8'h00, 8'h00, 8'h08, 11'd14, 8'd0, 8'd5);
    // hit and miss in the same cycle: hit scores but combo stays 0
    add(1, 10'd416, 8'h02, 8'h00, 10'd415, 8'h00, 8'h00, 8'h00, 11'd14, 8'd0, 8'd5);
    add(1, 10'd420, 8'h01, 8'h00, 10'd416, 8'h00, 8'h00, 8'h00, 11'd14, 8'd0, 8'd5);
    add(0, 10'd0,   8'h00, 8'h00, 10'd419, 8'h00, 8'h00, 8'h00, 11'd14, 8'd0, 8'd5);
    add(0, 10'd0,   8'h00, 8'h01, 10'd420, 8'h01, 8'h00, 8'h02, 11'd17, 8'd0, 8'd5);
    add(0, 10'd0,   8'h00, 8'h00, 10'd421, 8'h00, 8'h00, 8'h00, 11'd17, 8'd0, 8'd5);
    // wrap-around: note at 1022, press at tick 1 (delta +3)
    add(1, 10'd1022,8'h10, 8'h00, 10'd1020,8'h00, 8'h00, 8'h00, 11'd17, 8'd0, 8'd5);
    add(0, 10'd0,   8'h00, 8'h00, 10'd1021,8'h00, 8'h00, 8'h00, 11'd17, 8'd0, 8'd5);
    add(0, 10'd0,   8'h00, 8'h00, 10'd1022,8'h00, 8'h00, 8'h00, 11'd17, 8'd0, 8'd5);
    add(0, 10'd0,   8'h00, 8'h00, 10'd1023,8'h00, 8'h00, 8'h00, 11'd17, 8'd0, 8'd5);
    add(0, 10'd0,   8'h00, 8'h00, 10'd0,   8'h00, 8'h00, 8'h00, 11'd17, 8'd0, 8'd5);
    add(0, 10'd0,   8'h00, 8'h10, 10'd1,   8'h00, 8'h10, 8'h00, 11'd18, 8'd1, 8'd5);
    add(0, 10'd0,   8'h00, 8'h00, 10'd2,   8'h00, 8'h00, 8'h00, 11'd18, 8'd1, 8'd5);
    // reload of pending lane 5 misses the old note; load-cycle edges never judge new notes
    add(1, 10'd10,  8'h20, 8'h00, 10'd5,   8'h00, 8'h00, 8'h00, 11'd18, 8'd1, 8'd5);
    add(1, 10'd12,  8'h20, 8'h20, 10'd6,   8'h00, 8'h00, 8'h20, 11'd18, 8'd0, 8'd5);
    add(1, 10'd8,   8'h40, 8'h40, 10'd8,   8'h00, 8'h00, 8'h00, 11'd18, 8'd0, 8'd5);
    add(0, 10'd0,   8'h00, 8'h40, 10'd9,   8'h00, 8'h00, 8'h00, 11'd18, 8'd0, 8'd5);
    add(0, 10'd0,   8'h00, 8'h00, 10'd10,  8'h00, 8'h00, 8'h00, 11'd18, 8'd0, 8'd5);
    add(0, 10'd0,   8'h00, 8'h60, 10'd12,  8'h20, 8'h00, 8'h40, 11'd21, 8'd0, 8'd5);
    add(0, 10'd0,   8'h00, 8'h00, 10'd13,  8'h00, 8'h00, 8'h00, 11'd21, 8'd0, 8'd5);

    step();
    step();
    chk_a("reset0", 8'h00, 8'h00, 8'h00, 11'd0, 8'd0, 8'd0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive_a(vecs[i].nv, vecs[i].nt, vecs[i].nm, vecs[i].key, vecs[i].tk);
      step();
      chk_a($sformatf("v%0d", i), vecs[i].ep, vecs[i].eg, vecs[i].em,
            vecs[i].esc, vecs[i].eco, vecs[i].emx);
    end

    // mid-run reset with a key held and loads pending in the reset cycle
    drive_a(1'b1, 10'd30, 8'h80, 8'h00, 10'd20);
    step();
    rst = 1'b1;
    drive_a(1'b1, 10'd30, 8'h01, 8'h80, 10'd30);
    step();
    chk_a("rst_mid", 8'h00, 8'h00, 8'h00, 11'd0, 8'd0, 8'd0);
    rst = 1'b0;
    drive_a(1'b1, 10'd30, 8'h80, 8'h80, 10'd30);
    step();
    chk_a("rst_rel", 8'h00, 8'h00, 8'h00, 11'd0, 8'd0, 8'd0);
    drive_a(1'b0, 10'd0, 8'h00, 8'h80, 10'd30);
    step();
    chk_a("rst_held", 8'h00, 8'h00, 8'h00, 11'd0, 8'd0, 8'd0);
    drive_a(1'b0, 10'd0, 8'h00, 8'h00, 10'd31);
    step();
    drive_a(1'b0, 10'd0, 8'h00, 8'h80, 10'd31);
    step();
    chk_a("rst_hit", 8'h80, 8'h00, 8'h00, 11'd3, 8'd1, 8'd1);
    drive_a(1'b0, 10'd0, 8'h00, 8'h00, 10'd34);
    step();
    drive_a(1'b0, 10'd0, 8'h00, 8'h00, 10'd35);
    step();
    chk_a("rst_drop", 8'h00, 8'h00, 8'h00, 11'd3, 8'd1, 8'd1);

    // 4-bit score saturation
    drive_b(1'b1, 10'd50, 8'h0F, 8'h00, 10'd49);
    step();
    drive_b(1'b0, 10'd0, 8'h00, 8'h0F, 10'd50);
    step();
    chk("sat.score12", 32'(bus_b.score), 32'd12);
    chk("sat.perfect4", 32'(bus_b.perfect_mask), 32'h0F);
    drive_b(1'b1, 10'd60, 8'h30, 8'h00, 10'd51);
    step();
    drive_b(1'b0, 10'd0, 8'h00, 8'h30, 10'd60);
    step();
    chk("sat.score15", 32'(bus_b.score), 32'd15);
    chk("sat.combo6", 32'(bus_b.combo), 32'd6);
    drive_b(1'b1, 10'd61, 8'h01, 8'h00, 10'd61);
    step();
    drive_b(1'b0, 10'd0, 8'h00, 8'h01, 10'd61);
    step();
    chk("sat.hold", 32'(bus_b.score), 32'd15);
    chk("sat.combo7", 32'(bus_b.combo), 32'd7);
    chk("sat.max7", 32'(bus_b.max_combo), 32'd7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lane_judge_scorer.md
Name: lane_judge_scorer

Overview:
- Parametrised successor to the single-comparison score calculator.
- Judges user key presses against scheduled notes on LANES independent lanes, using game time from game_clock.
- Classifies each note as PERFECT, GOOD or MISS using timing windows, and accumulates a saturating score plus current and maximum combo.
- Sits between pattern_manager/input_manager and nanaseg_decoder.

Parameters:
LANES, 8, number of note lanes / key inputs
TICK_W, 10, width of game time counter (wraps modulo 2^TICK_W)
WIN_PERFECT, 1, max |key_time - note_time| for PERFECT (ticks)
WIN_GOOD, 3, max |key_time - note_time| for GOOD; must be > WIN_PERFECT and < 2^(TICK_W-1)
PTS_PERFECT, 3, points per PERFECT
PTS_GOOD, 1, points per GOOD
SCORE_W, 11, score width
COMBO_W, 8, combo / max_combo width

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
tick  input  TICK_W  current game time (counter10h)
note_valid  input  1  load strobe for a note set
note_time  input  TICK_W  scheduled hit time of the note set
note_mask  input  LANES  lanes receiving a note at note_time
user_key  input  LANES  level key state, 1 = pressed
perfect_mask  output  LANES  lanes judged PERFECT this cycle (1-cycle pulse)
good_mask  output  LANES  lanes judged GOOD this cycle
miss_mask  output  LANES  lanes judged MISS this cycle
score  output  SCORE_W  accumulated score, saturating
combo  output  COMBO_W  current consecutive-hit count, saturating
max_combo  output  COMBO_W  highest combo since reset

Behaviour:
- Reset (synchronous, active-high): all outputs 0; all pending flags cleared; key_prev <= user_key, so keys held through reset produce no edge.
- Per-lane state: pending bit and stored time pt[TICK_W]. One pending note per lane.
- Key edge: edge[i] = user_key[i] & ~key_prev[i]; key_prev updated every cycle.
- Delta: d = tick - pt, computed modulo 2^TICK_W and interpreted as signed TICK_W. Wrap-around is handled purely by modular arithmetic.
- Per-lane evaluation each cycle, in priority order, using the pending state before any load:
  - pending & edge & |d| <= WIN_PERFECT -> PERFECT; clear pending.
  - pending & edge & |d| <= WIN_GOOD -> GOOD; clear pending.
  - pending & d > WIN_GOOD -> MISS (timeout); clear pending.
  - Edge with no pending note, or with d < -WIN_GOOD -> ignored; no penalty and no state change.
- Note load: when note_valid is high, each lane with note_mask[i] = 1 sets pending and pt <= note_time.
  - If that lane still held an unjudged pending note after evaluation, the old note is flagged MISS in the same cycle.
  - A key edge in the load cycle is never applied to the newly loaded note.
- Outputs are registered; latency is one cycle from the evaluating tick/edge to the masks and counters.
- Masks are 1-cycle pulses, mutually exclusive per lane.
- Score: score <= min(score + PTS_PERFECT * popcount(perfect) + PTS_GOOD * popcount(good), 2^SCORE_W - 1).
  - The sum is computed at width SCORE_W + clog2(LANES) + 2 before saturating.
- Combo:
  - Any MISS this cycle -> combo <= 0, and hits in the same cycle are discarded from the combo.
  - Otherwise combo <= min(combo + hits, 2^COMBO_W - 1).
- max_combo <= max(max_combo, next combo).
- tick is assumed monotonic with at most one increment per cycle. Behaviour on backward jumps is unspecified except that no output goes X.
- Reset asserted mid-operation: next cycle all outputs and pending state are 0; any note_valid or edge in the reset cycle is dropped.

Test Plan:
- Lane 0 note at time 100; key 0 rises while tick = 100 -> next cycle perfect_mask = 0x01, score = 3, combo = 1, max_combo = 1.
- Lane 2 note at time 200; key rises at tick 203 -> good_mask = 0x04, score +1. Repeat with key at tick 196 -> GOOD. Repeat with key at tick 195 -> ignored; MISS pulses when tick reaches 204.
- Lane 1 note at time 300, no key -> miss_mask = 0x02 exactly once, in the cycle after tick = 304; combo drops from 5 to 0; max_combo stays 5.
- Lanes 0 and 3 note at time 400; both keys rise at tick 401 -> perfect_mask = 0x09, score +6, combo +2. Same setup with lane 3 missed instead -> combo = 0, score +3.
- Wrap-around: note_time = 1022, key rises at tick = 1 (d = +3) -> GOOD. SCORE_W = 4 override: 6 PERFECTs -> score saturates at 15 and holds.
- Pending lane 5 note reloaded before being judged -> MISS for the old note in the load cycle. Then assert reset for 1 cycle with a key held -> all outputs 0, no spurious edge after reset is released.
